// File: rtl/mult_div_unit.sv
// Multiply/divide unit with private HI/LO registers.
// Results are computed at launch and held in a pending pair; HI/LO are
// committed only when the latency counter expires, so they never change
// while busy. mthi/mtlo write directly when idle.
module mult_div_unit #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        iStart,
    input  logic [2:0]  iOp,
    input  logic [31:0] iA,
    input  logic [31:0] iB,
    input  logic        iRdSel,
    output logic        oBusy,
    output logic        oOccupy,
    output logic [31:0] oHI,
    output logic [31:0] oLO,
    output logic [31:0] oOut
);

    localparam int unsigned MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CW   = $clog2(MAXC + 1);

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5
    } op_e;

    logic [31:0]   hi_q, hi_d, lo_q, lo_d;
    logic [31:0]   phi_q, phi_d, plo_q, plo_d;
    logic          dz_q, dz_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic [63:0]        sprod, uprod;
    logic               div_zero, div_ovf;
    logic [31:0]        bdiv_u;
    logic signed [31:0] bdiv_s, sq, sr;
    logic [31:0]        uq, ur;
    logic [31:0]        res_hi, res_lo;

    // Both products are taken modulo 2^64; sign extension gives the signed one.
    assign sprod = {{32{iA[31]}}, iA} * {{32{iB[31]}}, iB};
    assign uprod = {32'b0, iA} * {32'b0, iB};

    // Divisor of zero is replaced by 1 so the datapath never divides by zero
    // (the result is discarded anyway). For MIN_INT / -1 the divisor becomes 1,
    // which yields the required quotient 0x80000000 and remainder 0.
    assign div_zero = (iB == '0);
    assign div_ovf  = (iA == 32'h8000_0000) && (iB == '1);
    assign bdiv_u   = div_zero ? 32'd1 : iB;
    assign bdiv_s   = (div_zero || div_ovf) ? 32'sd1 : $signed(iB);
    assign sq       = $signed(iA) / bdiv_s;
    assign sr       = $signed(iA) % bdiv_s;
    assign uq       = iA / bdiv_u;
    assign ur       = iA % bdiv_u;

    // Select the result pair for the operation being launched.
    always_comb begin
        res_hi = sprod[63:32];
        res_lo = sprod[31:0];
        case (iOp[1:0])
            2'd0: begin res_hi = sprod[63:32];   res_lo = sprod[31:0]; end
            2'd1: begin res_hi = uprod[63:32];   res_lo = uprod[31:0]; end
            2'd2: begin res_hi = $unsigned(sr);  res_lo = $unsigned(sq); end
            default: begin res_hi = ur;          res_lo = uq; end
        endcase
    end

    // Next-state: count down while busy and commit on expiry; otherwise accept a start.
    always_comb begin
        hi_d  = hi_q;
        lo_d  = lo_q;
        phi_d = phi_q;
        plo_d = plo_q;
        dz_d  = dz_q;
        cnt_d = cnt_q;
        if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1) && !dz_q) begin
                hi_d = phi_q;
                lo_d = plo_q;
            end
        end else if (iStart) begin
            case (op_e'(iOp))
                OP_MULT, OP_MULTU: begin
                    phi_d = res_hi;
                    plo_d = res_lo;
                    dz_d  = 1'b0;
                    cnt_d = CW'(MULT_CYCLES);
                end
                OP_DIV, OP_DIVU: begin
                    phi_d = res_hi;
                    plo_d = res_lo;
                    dz_d  = div_zero;
                    cnt_d = CW'(DIV_CYCLES);
                end
                OP_MTHI: hi_d = iA;
                OP_MTLO: lo_d = iA;
                default: ;
            endcase
        end
    end

    // State registers; reset discards any in-flight operation.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi_q  <= '0;
            lo_q  <= '0;
            phi_q <= '0;
            plo_q <= '0;
            dz_q  <= 1'b0;
            cnt_q <= '0;
        end else begin
            hi_q  <= hi_d;
            lo_q  <= lo_d;
            phi_q <= phi_d;
            plo_q <= plo_d;
            dz_q  <= dz_d;
            cnt_q <= cnt_d;
        end
    end

    assign oBusy   = (cnt_q != '0);
    assign oOccupy = (iStart & ~iOp[2]) | oBusy;
    assign oHI     = hi_q;
    assign oLO     = lo_q;
    assign oOut    = iRdSel ? hi_q : lo_q;

endmodule
